// File: rtl/string_refcount_update_queue.sv
// Reference-count adjustment queue: round-robin arbitration over NUM_PORTS requesters,
// tail coalescing of repeated handles, and a FIFO that emits one (handle, amount) per cycle.
module string_refcount_update_queue #(
  parameter int NUM_PORTS    = 2,
  parameter int FIFO_DEPTH   = 8,
  parameter int HANDLE_WIDTH = 64,
  parameter int AMOUNT_WIDTH = 64
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [NUM_PORTS-1:0]              in_valid,
  output logic [NUM_PORTS-1:0]              in_ready,
  input  logic [NUM_PORTS*HANDLE_WIDTH-1:0] in_handle,
  input  logic [NUM_PORTS*AMOUNT_WIDTH-1:0] in_amount,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [HANDLE_WIDTH-1:0]           out_handle,
  output logic [AMOUNT_WIDTH-1:0]           out_amount,
  output logic [$clog2(FIFO_DEPTH):0]       pending_count,
  output logic [31:0]                       drop_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  logic [HANDLE_WIDTH-1:0] r_mem_handle [FIFO_DEPTH];
  logic [AMOUNT_WIDTH-1:0] r_mem_amount [FIFO_DEPTH];
  logic [AW-1:0]           r_wr_ptr;
  logic [AW-1:0]           r_rd_ptr;
  logic [AW:0]             r_count;
  logic [31:0]             r_drop;
  logic [PW-1:0]           r_rr_ptr;

  logic [NUM_PORTS-1:0]    w_grant;
  logic [PW-1:0]           w_grant_idx;
  logic                    w_any;
  logic [HANDLE_WIDTH-1:0] w_req_handle;
  logic [AMOUNT_WIDTH-1:0] w_req_amount;
  logic [AW-1:0]           w_tail_idx;
  logic                    w_full;
  logic                    w_pop;
  logic                    w_discard;
  logic                    w_coalesce;
  logic                    w_accept;
  logic                    w_do_push;
  logic                    w_do_coal;
  logic                    w_do_drop;

  // NOTE: every signal driven from always_comb gets a default first so no path leaves it
  // unassigned; otherwise synthesis infers a latch to hold the old value.
  always_comb begin
    w_grant     = '0;
    w_grant_idx = r_rr_ptr;
    w_any       = 1'b0;
    for (int k = 1; k <= NUM_PORTS; k++) begin
      if (!w_any && in_valid[(int'(r_rr_ptr) + k) % NUM_PORTS]) begin
        w_any       = 1'b1;
        w_grant_idx = PW'((int'(r_rr_ptr) + k) % NUM_PORTS);
        w_grant[(int'(r_rr_ptr) + k) % NUM_PORTS] = 1'b1;
      end
    end
  end

  assign w_req_handle = in_handle[int'(w_grant_idx)*HANDLE_WIDTH +: HANDLE_WIDTH];
  assign w_req_amount = in_amount[int'(w_grant_idx)*AMOUNT_WIDTH +: AMOUNT_WIDTH];

  assign w_tail_idx = r_wr_ptr - AW'(1);
  assign w_full     = (r_count == (AW+1)'(FIFO_DEPTH));
  assign out_valid  = (r_count != '0);
  assign w_pop      = out_valid && out_ready;

  // Merging into the tail is unsafe only when that tail is the head leaving this cycle.
  assign w_discard  = (w_req_handle == '0) || (w_req_amount == '0);
  assign w_coalesce = !w_discard && out_valid &&
                      (r_mem_handle[w_tail_idx] == w_req_handle) &&
                      ((r_count > (AW+1)'(1)) || !w_pop);

  assign in_ready  = w_grant & {NUM_PORTS{w_discard || w_coalesce || !w_full}};
  assign w_accept  = w_any && |(in_valid & in_ready);
  assign w_do_drop = w_accept && w_discard;
  assign w_do_coal = w_accept && w_coalesce;
  assign w_do_push = w_accept && !w_discard && !w_coalesce;

  assign out_handle    = out_valid ? r_mem_handle[r_rd_ptr] : '0;
  assign out_amount    = out_valid ? r_mem_amount[r_rd_ptr] : '0;
  assign pending_count = r_count;
  assign drop_count    = r_drop;

  // NOTE: state registers use non-blocking assignments so every flop samples the
  // pre-edge values of its peers regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_drop   <= '0;
      r_rr_ptr <= PW'(NUM_PORTS - 1);
    end else begin
      if (w_accept)  r_rr_ptr <= w_grant_idx;
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)     r_rd_ptr <= r_rd_ptr + AW'(1);
      if (w_do_drop) r_drop   <= r_drop + 32'd1;
      case ({w_do_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // NOTE: the storage array is not reset; entries are only observable once counted,
  // and empty-FIFO outputs are forced to zero by the read mux instead.
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem_handle[r_wr_ptr] <= w_req_handle;
      r_mem_amount[r_wr_ptr] <= w_req_amount;
    end else if (w_do_coal) begin
      r_mem_amount[w_tail_idx] <= r_mem_amount[w_tail_idx] + w_req_amount;
    end
  end

endmodule
